// File: rtl/counter.sv
// Loadable free-running up-counter with registered terminal-count flag.
// Optional macro COUNTER_SAT_EN makes the counter saturate at all-ones instead of wrapping.
module counter #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] o,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] o_next;

  // NOTE: o_next gets a default on entry so every path assigns it and no latch is inferred.
  always_comb begin
    o_next = o + ONE;
`ifdef COUNTER_SAT_EN
    if (o == ALL_ONES) o_next = o;
`endif
    if (st) o_next = x;
  end

  // tc is registered from the next-state value so it always lines up with o.
  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o  <= RST_VAL;
      tc <= (RST_VAL == ALL_ONES);
    end else begin
      o  <= o_next;
      tc <= (o_next == ALL_ONES);
    end
  end

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: stimulus queues expected {o,tc}; a monitor pops and compares.
// Expectations follow COUNTER_SAT_EN when the macro is defined.
module tb_counter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             st;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] o;
  logic             tc;

  logic [WIDTH:0] exp_q[$];
  event           sample_ev;
  int             n_vec = 0;
  int             n_err = 0;

  counter #(.WIDTH(WIDTH), .RST_VAL('0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .st   (st),
    .x    (x),
    .o    (o),
    .tc   (tc)
  );

  always #5 clk = ~clk;

  // Monitor: compares after each rising edge, or after an asynchronous event.
  initial begin
    logic [WIDTH:0] e;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({o, tc} !== e)
          begin
            n_err++;
            $display("FAIL vec%0d: o=%0d tc=%0b, expected o=%0d tc=%0b",
                     n_vec, o, tc, e[WIDTH:1], e[0]);
          end
      end
    end
  end

  // Drive inputs for the next edge and queue the value expected after it.
  task automatic step(input logic r, input logic s, input logic [WIDTH-1:0] v,
                      input logic [WIDTH-1:0] eo, input logic et);
    @(negedge clk);
    rst_n = r;
    st    = s;
    x     = v;
    exp_q.push_back({eo, et});
  endtask

  // Assert reset mid-cycle while clk is high and check without waiting for an edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.push_back({{WIDTH{1'b0}}, 1'b0});
    ->sample_ev;
  endtask

  initial begin
    rst_n = 1'b0;
    st    = 1'b0;
    x     = '0;
    #2;
    exp_q.push_back({{WIDTH{1'b0}}, 1'b0});
    ->sample_ev;

    // Load then count, reload, x ignored while counting
    step(1, 1, 30, 30, 0);
    step(1, 0, 0, 31, 0);
    step(1, 0, 0, 32, 0);
    step(1, 1, 37, 37, 0);
    step(1, 0, 99, 38, 0);
    step(1, 0, 200, 39, 0);

    // Asynchronous reset from o=45
    step(1, 1, 45, 45, 0);
    async_reset();

    // Reset dominates a load, then counting resumes from 0
    step(0, 1, 77, 0, 0);
    step(0, 1, 77, 0, 0);
    step(1, 0, 77, 1, 0);

    // Terminal count and wrap / saturation
    step(1, 1, 254, 254, 0);
    step(1, 0, 0, 255, 1);
`ifdef COUNTER_SAT_EN
    step(1, 0, 0, 255, 1);
    step(1, 0, 0, 255, 1);
`else
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
`endif

    // Held load tracks x without counting
    step(1, 1, 5, 5, 0);
    step(1, 1, 9, 9, 0);
    step(1, 1, 200, 200, 0);

    // Load all-ones, then a load overrides it
    step(1, 1, 255, 255, 1);
    step(1, 1, 3, 3, 0);
    step(1, 0, 3, 4, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected values never compared, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
